issue_queue: RTL and testbench

//  Decoupling instruction queue between fetch and the 4-wide issue stage. Accepts bundles of up to

---
 rtl/issue_pkg.sv | 14 +
 rtl/iq_head_select.sv | 38 +++
 rtl/issue_queue.sv | 112 +++++++++++
 tb/tb_issue_queue.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_pkg.sv
// Shared opcode constants and helpers for the issue queue.
// Opcodes live in the top nibble of each instruction.
package issue_pkg;

  localparam logic [3:0] OP_NOP   = 4'b0000;
  localparam logic [3:0] OP_LOAD  = 4'b0010;
  localparam logic [3:0] OP_STORE = 4'b0100;
  localparam int         ISSUE_W  = 4;

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/iq_head_select.sv
// Combinational view of the four oldest queue entries.
// Empty slots read as zero instructions with OP_NOP opcodes.
module iq_head_select
  import issue_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int DEPTH   = 8,
  parameter int PTR_W   = $clog2(DEPTH),
  parameter int CNT_W   = PTR_W + 1
) (
  input  logic [PTR_W-1:0]                  head,
  input  logic [CNT_W-1:0]                  count,
  input  logic [DEPTH-1:0][INSTR_W-1:0]     mem,
  output logic [ISSUE_W-1:0][INSTR_W-1:0]   slot_instr,
  output logic [ISSUE_W-1:0][3:0]           slot_op,
  output logic [ISSUE_W-1:0]                v
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    idx        = '0;
    slot_instr = '0;
    slot_op    = '0;
    v          = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      idx  = head + PTR_W'(k);
      v[k] = count > CNT_W'(k);
      if (v[k]) begin
        slot_instr[k] = mem[idx];
        slot_op[k]    = mem[idx][INSTR_W-1 -: 4];
      end else begin
        slot_op[k]    = OP_NOP;
      end
    end
  end

endmodule

// File: rtl/issue_queue.sv
// Fetch-to-issue decoupling queue; issues the granted in-order
// prefix of the four oldest entries each cycle.
module issue_queue
  import issue_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int DEPTH   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   fetch_valid,
  input  logic [2:0]             fetch_count,
  input  logic [4*INSTR_W-1:0]   fetch_instr,
  output logic                   fetch_ready,
  output logic [3:0]             op1,
  output logic [3:0]             op2,
  output logic [3:0]             op3,
  output logic [3:0]             op4,
  input  logic                   ins2_ok,
  input  logic                   ins3_ok,
  input  logic                   ins4_ok,
  output logic [3:0]             issue_valid,
  output logic [4*INSTR_W-1:0]   issue_instr,
  input  logic                   issue_ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0][INSTR_W-1:0]   mem;
  logic [PTR_W-1:0]                head;
  logic [PTR_W-1:0]                tail;
  logic [CNT_W-1:0]                count;

  logic [ISSUE_W-1:0][INSTR_W-1:0] slot_instr;
  logic [ISSUE_W-1:0][3:0]         slot_op;
  logic [ISSUE_W-1:0]              v;
  logic [ISSUE_W-1:0]              g;

  logic                            fetch_ok;
  logic                            enq;
  logic [CNT_W-1:0]                enq_n;
  logic [CNT_W-1:0]                deq_n;

  iq_head_select #(
    .INSTR_W (INSTR_W),
    .DEPTH   (DEPTH),
    .PTR_W   (PTR_W),
    .CNT_W   (CNT_W)
  ) u_sel (
    .head       (head),
    .count      (count),
    .mem        (mem),
    .slot_instr (slot_instr),
    .slot_op    (slot_op),
    .v          (v)
  );

  assign op1         = slot_op[0];
  assign op2         = slot_op[1];
  assign op3         = slot_op[2];
  assign op4         = slot_op[3];
  assign issue_instr = slot_instr;

  // Grants are forced into a prefix even if the checker is not.
  assign g[0] = 1'b1;
  assign g[1] = ins2_ok;
  assign g[2] = ins2_ok & ins3_ok;
  assign g[3] = ins2_ok & ins3_ok & ins4_ok;

  assign issue_valid = v & g & {ISSUE_W{issue_ready & ~flush}};

  assign deq_n = CNT_W'(issue_valid[0]) + CNT_W'(issue_valid[1])
               + CNT_W'(issue_valid[2]) + CNT_W'(issue_valid[3]);

  assign fetch_ready = (CNT_W'(DEPTH) - count) >= CNT_W'(ISSUE_W);
  assign fetch_ok    = (fetch_count != 3'd0) && (fetch_count <= 3'd4);
  assign enq         = fetch_valid & fetch_ready & ~flush & fetch_ok;
  assign enq_n       = enq ? CNT_W'(fetch_count) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(deq_n);
      tail  <= tail + PTR_W'(enq_n);
      count <= count + enq_n - deq_n;
    end
  end

  // Entry storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    for (int k = 0; k < ISSUE_W; k++) begin
      if (enq && (3'(k) < fetch_count)) begin
        mem[tail + PTR_W'(k)] <= fetch_instr[k*INSTR_W +: INSTR_W];
      end
    end
  end

  a_fetch_count: assert property (
    @(posedge clk) disable iff (rst)
    (fetch_valid && fetch_ready && !flush) |-> fetch_ok
  );

endmodule

// File: tb/tb_issue_queue.sv
// Self-checking bench for issue_queue: vector table, corner
// sequences and random traffic against a queue-based model.
module tb_issue_queue;
  import issue_pkg::*;

  localparam int W = 16;
  localparam int D = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           flush = 1'b0;
  logic           fetch_valid = 1'b0;
  logic [2:0]     fetch_count = 3'd1;
  logic [4*W-1:0] fetch_instr = '0;
  logic           fetch_ready;
  logic [3:0]     op1, op2, op3, op4;
  logic           ins2_ok = 1'b0;
  logic           ins3_ok = 1'b0;
  logic           ins4_ok = 1'b0;
  logic [3:0]     issue_valid;
  logic [4*W-1:0] issue_instr;
  logic           issue_ready = 1'b0;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] q[$];

  issue_queue #(.INSTR_W(W), .DEPTH(D)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .fetch_valid (fetch_valid),
    .fetch_count (fetch_count),
    .fetch_instr (fetch_instr),
    .fetch_ready (fetch_ready),
    .op1         (op1),
    .op2         (op2),
    .op3         (op3),
    .op4         (op4),
    .ins2_ok     (ins2_ok),
    .ins3_ok     (ins3_ok),
    .ins4_ok     (ins4_ok),
    .issue_valid (issue_valid),
    .issue_instr (issue_instr),
    .issue_ready (issue_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fv;
    logic [2:0]  fc;
    logic [63:0] fi;
    logic        rdy;
    logic [3:0]  exp_iv;
    logic [15:0] exp_ops;
    logic        exp_fr;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] bundle(input logic [15:0] a,
    input logic [15:0] b, input logic [15:0] c, input logic [15:0] d);
    return {d, c, b, a};
  endfunction

  // Reference load/store checker: slot k granted while at most one
  // memory op sits among slots 1..k of the model queue.
  function automatic logic [2:0] model_grants();
    int m = 0;
    logic [2:0] r = '0;
    logic [3:0] op;
    for (int k = 0; k < 4; k++) begin
      op = (k < q.size()) ? q[k][W-1 -: 4] : OP_NOP;
      if (is_mem_op(op)) m++;
      if (k >= 1) r[k-1] = (m <= 1);
    end
    return r;
  endfunction

  task automatic drive(input logic fv, input logic [2:0] fc,
    input logic [63:0] fi, input logic rdy, input logic fl,
    input logic wr, input logic [2:0] ins);
    @(negedge clk);
    fetch_valid = fv;
    fetch_count = fc;
    fetch_instr = fi;
    issue_ready = rdy;
    flush       = fl;
    if (wr) {ins4_ok, ins3_ok, ins2_ok} = model_grants();
    else    {ins4_ok, ins3_ok, ins2_ok} = ins;
    #1;
  endtask

  task automatic commit();
    int n;
    int glen;
    logic fr;
    logic [3:0]  eiv;
    logic [15:0] eops;
    logic [63:0] einstr;
    logic [63:0] mask;
    fr   = (D - q.size()) >= 4;
    glen = 1 + int'(ins2_ok) + int'(ins2_ok & ins3_ok)
         + int'(ins2_ok & ins3_ok & ins4_ok);
    n    = (issue_ready && !flush) ?
           ((q.size() < glen) ? q.size() : glen) : 0;
    eiv    = 4'((1 << n) - 1);
    eops   = '0;
    einstr = '0;
    mask   = '0;
    for (int k = 0; k < 4; k++) begin
      if (k < q.size()) eops[15-4*k -: 4] = q[k][W-1 -: 4];
      if (k < n) begin
        einstr[k*W +: W] = q[k];
        mask[k*W +: W]   = '1;
      end
    end
    check("fetch_ready", 64'(fetch_ready), 64'(fr));
    check("issue_valid", 64'(issue_valid), 64'(eiv));
    check("ops", 64'({op1, op2, op3, op4}), 64'(eops));
    check("issue_instr", issue_instr & mask, einstr);
    if (flush) begin
      q.delete();
    end else begin
      for (int k = 0; k < n; k++) void'(q.pop_front());
      if (fetch_valid && fr)
        for (int k = 0; k < int'(fetch_count); k++)
          q.push_back(fetch_instr[k*W +: W]);
    end
    @(posedge clk);
  endtask

  task automatic idle(input logic rdy, input logic wr);
    drive(1'b0, 3'd1, '0, rdy, 1'b0, wr, 3'b000);
  endtask

  initial begin
    logic [63:0] b;
    logic [3:0]  rop;

    tbl[0] = '{1, 4, bundle(16'h1001, 16'h2002, 16'h1003, 16'h4004),
               1, 4'b0000, 16'h0000, 1};
    tbl[1] = '{0, 1, 64'h0, 1, 4'b0111, 16'h1214, 1};
    tbl[2] = '{0, 1, 64'h0, 1, 4'b0001, 16'h4000, 1};
    tbl[3] = '{1, 4, bundle(16'h2011, 16'h4012, 16'h2013, 16'h4014),
               1, 4'b0000, 16'h0000, 1};
    tbl[4] = '{0, 1, 64'h0, 1, 4'b0001, 16'h2424, 1};
    tbl[5] = '{0, 1, 64'h0, 1, 4'b0001, 16'h4240, 1};
    tbl[6] = '{0, 1, 64'h0, 1, 4'b0001, 16'h2400, 1};
    tbl[7] = '{0, 1, 64'h0, 1, 4'b0001, 16'h4000, 1};
    tbl[8] = '{0, 1, 64'h0, 1, 4'b0000, 16'h0000, 1};
    tbl[9] = '{0, 1, 64'h0, 0, 4'b0000, 16'h0000, 1};

    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    issue_ready = 1'b1;
    #1;
    check("reset_iv", 64'(issue_valid), 64'h0);
    check("reset_ops", 64'({op1, op2, op3, op4}), 64'h0);
    check("reset_fr", 64'(fetch_ready), 64'h1);

    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].fv, tbl[i].fc, tbl[i].fi, tbl[i].rdy, 1'b0, 1'b1, 3'b0);
      check($sformatf("tbl%0d_iv", i), 64'(issue_valid), 64'(tbl[i].exp_iv));
      check($sformatf("tbl%0d_ops", i), 64'({op1, op2, op3, op4}),
            64'(tbl[i].exp_ops));
      check($sformatf("tbl%0d_fr", i), 64'(fetch_ready), 64'(tbl[i].exp_fr));
      commit();
    end

    b = bundle(16'h1101, 16'h1102, 16'h1103, 16'h1104);
    drive(1, 3, b, 0, 0, 1, 3'b0); commit();
    idle(1, 1); commit();
    drive(1, 1, bundle(16'h1201, 0, 0, 0), 0, 0, 1, 3'b0); commit();
    drive(1, 4, bundle(16'h1202, 16'h1203, 16'h1204, 16'h1205),
          0, 0, 1, 3'b0); commit();
    drive(1, 4, bundle(16'h1ee1, 16'h1ee2, 16'h1ee3, 16'h1ee4),
          0, 0, 1, 3'b0);
    check("t4_fr_cnt5", 64'(fetch_ready), 64'h0);
    commit();
    idle(1, 0); commit();
    drive(1, 4, bundle(16'h1206, 16'h1207, 16'h1208, 16'h1209),
          0, 0, 1, 3'b0); commit();
    idle(0, 1);
    check("t4_fr_cnt8", 64'(fetch_ready), 64'h0);
    check("t4_head_op", 64'({op1, op2, op3, op4}), 64'h1111);
    commit();
    idle(1, 1);
    check("t4_iv_wrap", 64'(issue_valid), 64'hf);
    check("t4_instr_wrap", issue_instr,
          bundle(16'h1202, 16'h1203, 16'h1204, 16'h1205));
    commit();
    idle(1, 1); commit();

    drive(1, 2, bundle(16'h1301, 16'h1302, 0, 0), 0, 0, 1, 3'b0); commit();
    drive(1, 4, bundle(16'h3303, 16'h5304, 16'h6305, 16'h7306),
          1, 0, 1, 3'b0);
    check("t5_iv", 64'(issue_valid), 64'h3);
    commit();
    idle(0, 1);
    check("t5_ops", 64'({op1, op2, op3, op4}), 64'h3567);
    commit();
    idle(1, 1); commit();

    drive(1, 4, bundle(16'h1401, 16'h1402, 16'h1403, 16'h1404),
          0, 0, 1, 3'b0); commit();
    drive(1, 2, bundle(16'h1405, 16'h1406, 0, 0), 0, 0, 1, 3'b0); commit();
    drive(1, 4, bundle(16'h1fff, 16'h1ffe, 16'h1ffd, 16'h1ffc),
          1, 1, 1, 3'b0);
    check("t6_iv_flush", 64'(issue_valid), 64'h0);
    commit();
    idle(1, 1);
    check("t6_iv_after", 64'(issue_valid), 64'h0);
    check("t6_ops_after", 64'({op1, op2, op3, op4}), 64'h0);
    check("t6_fr_after", 64'(fetch_ready), 64'h1);
    commit();

    drive(1, 4, bundle(16'h1501, 16'h2502, 16'h1503, 16'h4504),
          0, 0, 1, 3'b0); commit();
    drive(1, 1, bundle(16'h1505, 0, 0, 0), 0, 0, 1, 3'b0);
    commit();
    #2;
    rst = 1'b1;
    issue_ready = 1'b1;
    fetch_valid = 1'b0;
    #1;
    check("t1_rst_iv", 64'(issue_valid), 64'h0);
    check("t1_rst_ops", 64'({op1, op2, op3, op4}), 64'h0);
    check("t1_rst_fr", 64'(fetch_ready), 64'h1);
    #1 rst = 1'b0;
    q.delete();

    for (int i = 0; i < 400; i++) begin
      b = '0;
      for (int k = 0; k < 4; k++) begin
        case ($urandom_range(0, 4))
          0: rop = OP_LOAD;
          1: rop = OP_STORE;
          2: rop = OP_NOP;
          default: rop = 4'($urandom_range(1, 15));
        endcase
        b[k*W +: W] = {rop, 12'($urandom)};
      end
      drive(1'($urandom_range(0, 2) != 0), 3'($urandom_range(1, 4)), b,
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 24) == 0),
            1'($urandom), 3'($urandom));
      commit();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
